mod6_histogram: RTL and testbench
=================================

Name: mod6_histogram

Overview:
Downstream consumer of the modulo-6 reducer output. Accepts a stream of mod-6 residues over a valid/ready handshake and counts occurrences of each residue 0..5 in per-bin counters over a fixed sample window. When the window completes, the block freezes and raises done. Software or a bench then reads the bins through a registered read port. Residues 6 and 7 are illegal; they set a sticky error flag.

Parameters:
CNT_W, 8, width of each bin counter and of rd_count; bins saturate at 2^CNT_W-1
WINDOW, 48, accepted samples per collection window; legal range 1..255

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mod6_value  input  3  residue from modulo-6 stage
in_valid  input  1  mod6_value is valid this cycle
in_ready  output  1  block can accept a sample this cycle
clear  input  1  synchronous restart of collection
rd_bin  input  3  bin index to read (0..5)
rd_count  output  CNT_W  registered count of bin rd_bin
total  output  8  samples accepted in the current window
done  output  1  window complete; bins frozen
err  output  1  sticky; an illegal residue (6 or 7) was accepted

Behaviour:
- Reset (rst_n low, asynchronous): all 6 bins=0, total=0, rd_count=0, done=0, err=0, state=COLLECT.
- States: COLLECT, DONE. Encoded in a state register; done = (state==DONE).
- in_ready = (state==COLLECT) && !clear. This is combinational.
- accept = in_valid && in_ready. No other condition accepts a sample. The sender may hold in_valid while in_ready is low; that sample is not consumed.
- On accept with mod6_value 0..5: bin[mod6_value] increments by 1 and saturates at 2^CNT_W-1 (no wrap). total increments by 1.
- On accept with mod6_value 6 or 7: no bin changes, err<=1 (sticky), total increments by 1. The illegal sample counts toward the window.
- COLLECT->DONE: on the accept that makes total reach WINDOW. done=1 and in_ready=0 from the next cycle.
- DONE: bins, total and err hold. in_valid is ignored. The block stays in DONE until clear or reset.
- clear=1, any state: on the next edge, bins=0, total=0, err=0, state=COLLECT. in_ready is 0 during the clear cycle, so any sample presented in that cycle is not accepted. clear takes priority over accept. rd_count is unaffected by clear in that cycle and reads the new values afterwards.
- Read port:
  - rd_count <= bin[rd_bin] every cycle, giving 1-cycle latency.
  - rd_bin 6 or 7 returns 0.
  - Reads are allowed in any state, including during collection.
  - A read of a bin that increments in the same cycle returns the pre-increment value. The new value appears one cycle later.
- total is a direct register output with 0 latency. It never exceeds WINDOW.
- Reset mid-window: everything clears immediately, regardless of clk.
- Back-to-back accepts every cycle are supported at full throughput (1 sample/clk).

Test Plan:
- Reset, then feed residues 0,1,2,3,4,5 repeated 8 times with in_valid held high (WINDOW=48) -> in_ready=1 for 48 cycles; done=1 the cycle after the 48th accept; total=48; each bin reads 8 via rd_bin 0..5 (1-cycle latency); err=0.
- After done, drive in_valid=1 with value 3 for 5 cycles -> in_ready=0; bin3 stays 8; total stays 48.
- Pulse clear for 1 cycle with in_valid=1, value 2 -> no accept that cycle; all bins 0, total=0, done=0 next cycle; accepting resumes on the following cycle.
- Feed values 7 then 6 then 1 -> err=1 after the first accept and stays 1; bin1=1; total=3; bins 0 and 2..5 = 0; rd_bin=6 and rd_bin=7 read 0.
- CNT_W=2, WINDOW=10, feed value 4 ten times -> bin4 saturates at 3; total=10; done=1.
- Assert rst_n low between clock edges mid-window (total=20) -> outputs go to 0 asynchronously; first accept after release gives total=1.

Source files
------------

// File: rtl/mod6_histogram.sv
// Histogram of mod-6 residues over a fixed sample window, with a registered bin read port.
// Illegal residues 6/7 count toward the window and set a sticky error flag.
module mod6_histogram #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mod6_value,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    input  logic [2:0]       rd_bin,
    output logic [CNT_W-1:0] rd_count,
    output logic [7:0]       total,
    output logic             done,
    output logic             err
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } state_t;

    localparam int              NUM_BINS = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [7:0]       WIN     = 8'(WINDOW);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bins_q [NUM_BINS];
    logic [CNT_W-1:0] bins_d [NUM_BINS];
    logic [7:0]       total_q, total_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic             accept;

    assign in_ready = (state_q == ST_COLLECT) && !clear;
    assign accept   = in_valid && in_ready;
    assign done     = (state_q == ST_DONE);
    assign total    = total_q;
    assign err      = err_q;
    assign rd_count = rd_count_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d = state_q;
        bins_d  = bins_q;
        total_d = total_q;
        err_d   = err_q;

        if (clear) begin
            state_d = ST_COLLECT;
            total_d = '0;
            err_d   = 1'b0;
            for (int b = 0; b < NUM_BINS; b++) begin
                bins_d[b] = '0;
            end
        end else if (accept) begin
            total_d = total_q + 8'd1;
            if (mod6_value > 3'd5) begin
                err_d = 1'b1;
            end
            // Saturating increment of the addressed bin; illegal residues match no bin.
            for (int b = 0; b < NUM_BINS; b++) begin
                if (mod6_value == 3'(b) && bins_q[b] != CNT_MAX) begin
                    bins_d[b] = bins_q[b] + CNT_ONE;
                end
            end
            if (total_q + 8'd1 == WIN) begin
                state_d = ST_DONE;
            end
        end
    end

    // Reads the registered bins, so a same-cycle increment is seen one cycle later.
    always_comb begin
        rd_count_d = '0;
        for (int b = 0; b < NUM_BINS; b++) begin
            if (rd_bin == 3'(b)) begin
                rd_count_d = bins_q[b];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            total_q    <= '0;
            err_q      <= 1'b0;
            rd_count_q <= '0;
            // NOTE: the bin array is small register storage, so it is reset like any flop.
            for (int b = 0; b < NUM_BINS; b++) begin
                bins_q[b] <= '0;
            end
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            err_q      <= err_d;
            rd_count_q <= rd_count_d;
            bins_q     <= bins_d;
        end
    end

endmodule

// File: tb/tb_mod6_histogram.sv
// Directed bench for mod6_histogram: default window of 48 plus a CNT_W=2/WINDOW=10 saturation instance.
module tb_mod6_histogram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] mod6_value;
    logic       in_valid;
    logic       in_ready;
    logic       clear;
    logic [2:0] rd_bin;
    logic [7:0] rd_count;
    logic [7:0] total;
    logic       done;
    logic       err;

    logic [2:0] sat_value;
    logic       sat_valid;
    logic       sat_ready;
    logic       sat_clear;
    logic [2:0] sat_rd_bin;
    logic [1:0] sat_rd_count;
    logic [7:0] sat_total;
    logic       sat_done;
    logic       sat_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod6_histogram #(.CNT_W(8), .WINDOW(48)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mod6_value (mod6_value),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clear      (clear),
        .rd_bin     (rd_bin),
        .rd_count   (rd_count),
        .total      (total),
        .done       (done),
        .err        (err)
    );

    mod6_histogram #(.CNT_W(2), .WINDOW(10)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .mod6_value (sat_value),
        .in_valid   (sat_valid),
        .in_ready   (sat_ready),
        .clear      (sat_clear),
        .rd_bin     (sat_rd_bin),
        .rd_count   (sat_rd_count),
        .total      (sat_total),
        .done       (sat_done),
        .err        (sat_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        mod6_value = '0;
        in_valid   = 1'b0;
        clear      = 1'b0;
        rd_bin     = '0;
        sat_value  = '0;
        sat_valid  = 1'b0;
        sat_clear  = 1'b0;
        sat_rd_bin = '0;

        #2;
        check("reset_total", total, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_rd_count", rd_count, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_sat_total", sat_total, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full window of 0..5 repeated 8 times, one accept per cycle.
        for (int i = 0; i < 48; i++) begin
            in_valid   = 1'b1;
            mod6_value = 3'(i % 6);
            #1;
            check("window_in_ready", in_ready, 1);
            step();
            check("window_total", total, 32'(i + 1));
            check("window_done", done, (i == 47) ? 32'd1 : 32'd0);
        end
        check("done_in_ready", in_ready, 0);

        // Samples offered while done are ignored.
        mod6_value = 3'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            check("frozen_in_ready", in_ready, 0);
            check("frozen_total", total, 48);
            check("frozen_done", done, 1);
        end
        in_valid = 1'b0;
        for (int b = 0; b < 6; b++) begin
            rd_bin = 3'(b);
            step();
            check("window_bin", rd_count, 8);
        end
        check("window_err", err, 0);

        // Clear blocks the sample offered alongside it; acceptance resumes the cycle after.
        in_valid   = 1'b1;
        mod6_value = 3'd2;
        clear      = 1'b1;
        #1;
        check("clear_in_ready", in_ready, 0);
        step();
        clear = 1'b0;
        #1;
        check("clear_total", total, 0);
        check("clear_done", done, 0);
        check("clear_in_ready_after", in_ready, 1);
        step();
        check("resume_total", total, 1);
        in_valid = 1'b0;
        rd_bin   = 3'd2;
        step();
        check("resume_bin2", rd_count, 1);
        rd_bin = 3'd3;
        step();
        check("cleared_bin3", rd_count, 0);

        clear = 1'b1;
        step();
        clear = 1'b0;

        // Illegal residues set sticky err and count toward total.
        in_valid   = 1'b1;
        mod6_value = 3'd7;
        step();
        check("illegal7_err", err, 1);
        check("illegal7_total", total, 1);
        mod6_value = 3'd6;
        step();
        check("illegal6_err", err, 1);
        check("illegal6_total", total, 2);
        mod6_value = 3'd1;
        step();
        check("legal_err_sticky", err, 1);
        check("legal_total", total, 3);
        in_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            rd_bin = 3'(b);
            step();
            check("illegal_bin", rd_count, (b == 1) ? 32'd1 : 32'd0);
        end

        // Read of a bin incrementing in the same cycle returns the old count.
        rd_bin     = 3'd1;
        in_valid   = 1'b1;
        mod6_value = 3'd1;
        step();
        check("same_cycle_read_old", rd_count, 1);
        check("same_cycle_total", total, 4);
        in_valid = 1'b0;
        step();
        check("same_cycle_read_new", rd_count, 2);

        // Asynchronous reset mid-window at total=20.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid   = 1'b1;
            mod6_value = (i == 0) ? 3'd7 : 3'(i % 6);
            step();
        end
        in_valid = 1'b0;
        step();
        check("mid_total", total, 20);
        check("mid_err", err, 1);
        check("mid_bin1", rd_count, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_total", total, 0);
        check("async_err", err, 0);
        check("async_done", done, 0);
        check("async_rd_count", rd_count, 0);
        #2;
        rst_n = 1'b1;
        in_valid   = 1'b1;
        mod6_value = 3'd0;
        step();
        check("post_reset_total", total, 1);
        in_valid = 1'b0;

        // Saturation instance: value 4 ten times into a 2-bit bin.
        sat_valid = 1'b1;
        sat_value = 3'd4;
        for (int i = 0; i < 10; i++) begin
            step();
            check("sat_total", sat_total, 32'(i + 1));
            check("sat_done", sat_done, (i == 9) ? 32'd1 : 32'd0);
        end
        sat_valid  = 1'b0;
        sat_rd_bin = 3'd4;
        step();
        check("sat_bin4", sat_rd_count, 3);
        check("sat_ready", sat_ready, 0);
        check("sat_err", sat_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
